// File: rtl/stopwatch_defs.sv
// -----------------------------------------------------------------------------
// stopwatch_defs
//   Definitions shared by the stopwatch control stage and the decade counters.
//   The mode code is the only control word between the two. The counters act
//   on it on every edge where tick is high.
//     MODE_W      width of the mode bus
//     mode_e      IDLE=0, RUN=1, CLEAR=2 (synchronous clear), PAUSE=3.
//                 Codes 4-7 are never driven.
// -----------------------------------------------------------------------------
package stopwatch_defs;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_IDLE  = 3'd0,
      MODE_RUN   = 3'd1,
      MODE_CLEAR = 3'd2,
      MODE_PAUSE = 3'd3
   } mode_e;

endpackage : stopwatch_defs

// File: rtl/stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_if
//   Bundles the button inputs and the control outputs of stopwatch_ctrl.
//     btn_ss   raw start/stop button (asynchronous, active-high)
//     btn_clr  raw clear button (asynchronous, active-high)
//     mode     control code to the decade counter chain
//     tick     one-clk count-enable pulse
//     running  LED: state is RUN
//     paused   LED: state is PAUSE
//   master : the control stage (drives mode/tick/LEDs)
//   slave  : the board / counter side (drives the buttons)
// -----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
   import stopwatch_defs::*;

   logic              btn_ss;
   logic              btn_clr;
   logic [MODE_W-1:0] mode;
   logic              tick;
   logic              running;
   logic              paused;

   modport master (
      input  btn_ss,
      input  btn_clr,
      output mode,
      output tick,
      output running,
      output paused
   );

   modport slave (
      output btn_ss,
      output btn_clr,
      input  mode,
      input  tick,
      input  running,
      input  paused
   );

endinterface : stopwatch_ctrl_if

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Conditions one push-button for the stopwatch control stage. The stages are
//   a 2-flop synchronizer, a stability counter and a press-pulse generator.
//   The debounced level changes only after the synchronized input has differed
//   from it on DB_CYCLES consecutive edges. A one-cycle press pulse is emitted
//   on a debounced 0->1 change only. A clean raw edge produces its press pulse
//   2 + DB_CYCLES edges later.
//   Ports:
//     clk    system clock
//     rst    asynchronous, active-high reset
//     btn    raw button level (asynchronous)
//     press  registered one-cycle pulse on an accepted press
//   Parameters:
//     DB_CYCLES  stable synchronized cycles needed to accept a change (>= 1)
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DB_CYCLES = 250_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   // A 1-bit counter is still needed when DB_CYCLES == 1. In that case the
   // counter only ever holds 0.
   localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // NOTE: state flops use non-blocking assignment so that every right-hand side
   // reads the value from before the edge. The synchronizer chain depends on
   // this ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != level) begin
            if (cnt == CNT_MAX) begin
               level <= sync2;
               cnt   <= '0;
               // A pulse is produced on the accepted rising level only.
               press <= sync2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            // Any agreement restarts the stability window. This rejects bounce.
            cnt <= '0;
         end
      end
   end

endmodule : btn_debounce

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control stage ahead of the decimal seconds counter chain. It has three
//   parts: two debounced buttons, a four-state control FSM, and a prescaler
//   that produces the count-enable tick.
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     sw   stopwatch_ctrl_if.master. It carries btn_ss and btn_clr in, and
//          mode, tick, running and paused out. All outputs are registered.
//   Parameters:
//     DIV        clk cycles per tick period while running (>= 2)
//     DB_CYCLES  debounce length handed to both button conditioners (>= 1)
//   Behaviour:
//     IDLE -ss-> RUN -ss-> PAUSE -ss-> RUN. clr from any state goes to CLEAR,
//     and clr wins over ss. CLEAR lasts one cycle and then returns to IDLE.
//     tick is raised for the CLEAR cycle, so the counters act on mode==CLEAR.
//     While running, the prescaler ticks every DIV enabled cycles. In PAUSE it
//     holds its count, so a resumed period finishes the remainder. In IDLE and
//     CLEAR it is held at 0.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
   import stopwatch_defs::*;
#(
   parameter int DIV       = 50_000_000,
   parameter int DB_CYCLES = 250_000
) (
   input  logic              clk,
   input  logic              rst,
   stopwatch_ctrl_if.master  sw
);

   localparam int            PW      = $clog2(DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   logic          ss_press;
   logic          clr_press;

   mode_e         state_q;
   mode_e         state_d;
   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;
   logic          pend_q;
   logic          pend_d;
   logic          tick_q;
   logic          tick_d;
   logic          running_q;
   logic          paused_q;

   // ---------------------------------------------------------------- buttons
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
      .clk   (clk),
      .rst   (rst),
      .btn   (sw.btn_ss),
      .press (ss_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk   (clk),
      .rst   (rst),
      .btn   (sw.btn_clr),
      .press (clr_press)
   );

   // ------------------------------------------------------- next-state logic
   // NOTE: every signal assigned here gets its default first. Any path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MODE_IDLE:  if (ss_press) state_d = MODE_RUN;
         MODE_RUN:   if (ss_press) state_d = MODE_PAUSE;
         MODE_PAUSE: if (ss_press) state_d = MODE_RUN;
         MODE_CLEAR: state_d = MODE_IDLE;
         default:    state_d = MODE_IDLE;
      endcase
      // clr overrides everything. This includes a second clr during CLEAR.
      if (clr_press) state_d = MODE_CLEAR;
   end

   // -------------------------------------------------------------- prescaler
   // Each RUN cycle advances the count once, on the edge that ends it.
   // Suppose the period completes on the same edge that enters PAUSE. The tick
   // cannot be shown in PAUSE, so it is held in pend and released on the edge
   // that resumes RUN. This keeps every period at exactly DIV enabled cycles.
   always_comb begin
      pre_d  = pre_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      case (state_d)
         MODE_RUN: begin
            if (state_q == MODE_RUN) begin
               if (pre_q == PRE_MAX) begin
                  pre_d  = '0;
                  tick_d = 1'b1;
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end else begin
               // Entering RUN from IDLE (count already 0) or from PAUSE (held).
               tick_d = pend_q;
               pend_d = 1'b0;
            end
         end
         MODE_PAUSE: begin
            if (state_q == MODE_RUN) begin
               if (pre_q == PRE_MAX) begin
                  pre_d  = '0;
                  pend_d = 1'b1;
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end
         end
         MODE_CLEAR: begin
            pre_d  = '0;
            pend_d = 1'b0;
            tick_d = 1'b1;
         end
         default: begin
            pre_d  = '0;
            pend_d = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------- registers
   // The outputs are taken from the next state. mode, tick and the LEDs
   // therefore change together on one edge, and no button path reaches an
   // output combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= MODE_IDLE;
         pre_q     <= '0;
         pend_q    <= 1'b0;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         pend_q    <= pend_d;
         tick_q    <= tick_d;
         running_q <= (state_d == MODE_RUN);
         paused_q  <= (state_d == MODE_PAUSE);
      end
   end

   assign sw.mode    = state_q;
   assign sw.tick    = tick_q;
   assign sw.running = running_q;
   assign sw.paused  = paused_q;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Bench for stopwatch_ctrl with DIV=4 and DB_CYCLES=3.
//   Each table row gives the button levels driven for one cycle. It also gives
//   the mode and tick expected right after the following clock edge. Rows are
//   queued as they are driven and checked one edge later.
//   Timing used to build the table, for a clean edge on row r:
//     the press pulse is high after edge r+4;
//     the FSM moves on edge r+5;
//     a RUN entered on edge t ticks after edges t+4, t+8, ...
//   After the table, hand-written sequences cover reset values and an
//   asynchronous reset in the middle of a period.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;
   import stopwatch_defs::*;

   localparam int DIV = 4;
   localparam int DB  = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
      .clk (clk),
      .rst (rst),
      .sw  (bus)
   );

   typedef struct {
      logic       ss;
      logic       clr;
      logic [2:0] mode;
      logic       tick;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input int row,
                        input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic seg(input int n, input logic ss, input logic clr,
                      input logic [2:0] m, input logic t);
      vec_t v;
      v.ss = ss; v.clr = clr; v.mode = m; v.tick = t;
      repeat (n) vecs.push_back(v);
   endtask

   // Hard bound on run time. No test gets near it.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- test 1: start, long hold, first ticks (rows 0-27)
      seg(10, 0, 0, MODE_IDLE, 0);
      seg(5,  1, 0, MODE_IDLE, 0);     // ss high rows 10-19
      seg(4,  1, 0, MODE_RUN,  0);     // RUN entered on edge 15
      seg(1,  1, 0, MODE_RUN,  1);     // row 19 = +4
      seg(3,  0, 0, MODE_RUN,  0);
      seg(1,  0, 0, MODE_RUN,  1);     // row 23 = +8
      seg(3,  0, 0, MODE_RUN,  0);
      seg(1,  0, 0, MODE_RUN,  1);     // row 27 = +12
      // ---------------- test 2: pause and resume (rows 28-46)
      seg(1,  0, 0, MODE_RUN,  0);
      seg(2,  1, 0, MODE_RUN,  0);     // ss pressed 2 cycles after the tick
      seg(1,  1, 0, MODE_RUN,  1);     // row 31
      seg(2,  1, 0, MODE_RUN,  0);
      seg(1,  1, 0, MODE_PAUSE, 0);    // row 34, prescaler holds at 3
      seg(5,  0, 0, MODE_PAUSE, 0);
      seg(5,  1, 0, MODE_PAUSE, 0);    // second press on row 40
      seg(1,  1, 0, MODE_RUN,  0);     // row 45 resumes
      seg(1,  0, 0, MODE_RUN,  1);     // 1 remaining cycle, then tick
      // ---------------- test 3: clear from RUN, then restart (rows 47-69)
      seg(1,  0, 0, MODE_RUN,  0);
      seg(2,  0, 1, MODE_RUN,  0);     // clr pressed on row 48
      seg(1,  0, 1, MODE_RUN,  1);     // row 50
      seg(2,  0, 1, MODE_RUN,  0);
      seg(1,  0, 1, MODE_CLEAR, 1);    // row 53: single CLEAR cycle with tick
      seg(6,  0, 0, MODE_IDLE, 0);
      seg(5,  1, 0, MODE_IDLE, 0);     // restart on row 60
      seg(4,  0, 0, MODE_RUN,  0);     // RUN from edge 65, prescaler from 0
      seg(1,  0, 0, MODE_RUN,  1);     // row 69
      // ---------------- test 4: simultaneous presses in PAUSE (rows 70-93)
      seg(1,  0, 0, MODE_RUN,  0);
      seg(2,  1, 0, MODE_RUN,  0);     // ss pressed on row 71
      seg(1,  1, 0, MODE_RUN,  1);     // row 73
      seg(2,  1, 0, MODE_RUN,  0);
      seg(5,  0, 0, MODE_PAUSE, 0);    // row 76
      seg(5,  1, 1, MODE_PAUSE, 0);    // both rise on row 81
      seg(1,  0, 0, MODE_CLEAR, 1);    // row 86: clr wins
      seg(7,  0, 0, MODE_IDLE, 0);
      // ---------------- test 5: bounce rejection, then clean press (94-129)
      for (int k = 0; k < 20; k++)
         seg(1, ((k / 2) % 2 == 0) ? 1'b1 : 1'b0, 0, MODE_IDLE, 0);
      seg(4,  0, 0, MODE_IDLE, 0);
      seg(5,  1, 0, MODE_IDLE, 0);     // clean 5-cycle press on row 118
      seg(4,  0, 0, MODE_RUN,  0);     // row 123
      seg(1,  0, 0, MODE_RUN,  1);     // row 127
      seg(2,  0, 0, MODE_RUN,  0);     // rows 128-129, prescaler reaches 2

      // ---------------- reset values
      rst         = 1'b1;
      bus.btn_ss  = 1'b0;
      bus.btn_clr = 1'b0;
      step();
      step();
      check("reset_mode",    -1, 32'(bus.mode),    32'(MODE_IDLE));
      check("reset_tick",    -1, 32'(bus.tick),    0);
      check("reset_running", -1, 32'(bus.running), 0);
      check("reset_paused",  -1, 32'(bus.paused),  0);
      rst = 1'b0;

      // ---------------- table: drive, queue expectation, check after edge
      for (int i = 0; i < vecs.size(); i++) begin
         vec_t e;
         bus.btn_ss  = vecs[i].ss;
         bus.btn_clr = vecs[i].clr;
         sb.push_back(vecs[i]);
         step();
         e = sb.pop_front();
         check("mode",    i, 32'(bus.mode),    32'(e.mode));
         check("tick",    i, 32'(bus.tick),    32'(e.tick));
         check("running", i, 32'(bus.running), (e.mode == MODE_RUN)   ? 1 : 0);
         check("paused",  i, 32'(bus.paused),  (e.mode == MODE_PAUSE) ? 1 : 0);
      end

      // ---------------- test 6: asynchronous reset between edges mid-period
      check("pre_rst_mode", 200, 32'(bus.mode), 32'(MODE_RUN));
      #3;
      rst = 1'b1;
      #1;                              // no clock edge since rst rose
      check("async_rst_mode",    201, 32'(bus.mode),    32'(MODE_IDLE));
      check("async_rst_tick",    201, 32'(bus.tick),    0);
      check("async_rst_running", 201, 32'(bus.running), 0);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("post_rst_tick", 210 + i, 32'(bus.tick), 0);
         check("post_rst_mode", 210 + i, 32'(bus.mode), 32'(MODE_IDLE));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_stopwatch_ctrl

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Upstream control stage for the decimal seconds counter chain of the stopwatch display.
- Debounces the start/stop and clear push-buttons and runs a four-state control FSM.
- Emits a 3-bit mode code, `mode`, that the decade counter consumes as its control input; code 2 = synchronous clear.
- Emits the prescaled count-enable pulse, `tick`, that advances the counter once per period.

Parameters:
- DIV, 50_000_000, clk cycles per tick period in RUN; minimum 2.
- DB_CYCLES, 250_000, consecutive stable synchronized cycles required to accept a button level change; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- btn_ss  input  1  raw start/stop button; asynchronous, active-high.
- btn_clr  input  1  raw clear button; asynchronous, active-high.
- mode  output  3  control code to counter: 0 IDLE, 1 RUN, 2 CLEAR, 3 PAUSE; codes 4-7 never driven.
- tick  output  1  one-clk-wide count-enable pulse.
- running  output  1  high while state is RUN (LED).
- paused  output  1  high while state is PAUSE (LED).

Behaviour:
- Reset is asynchronous. It clears all flops, including the synchronizers, the debounce counters and the prescaler.
- Reset values: state=IDLE, mode=0, tick=0, running=0, paused=0, debounced levels=0.

Button path (per button):
- Input passes through a 2-flop synchronizer.
- A debounce counter counts while the synchronized level differs from the debounced level, and resets to 0 whenever they match.
- When the count reaches DB_CYCLES-1 with the mismatch still present, the debounced level flips and the counter clears.
- A 1-cycle press pulse is generated on the debounced 0->1 transition only. Release produces no pulse.
- Latency, raw edge to press pulse: 2 + DB_CYCLES cycles for a clean edge.

FSM (registered; transitions on the clk edge where the press pulse is high):
- IDLE: ss -> RUN.
- RUN: ss -> PAUSE.
- PAUSE: ss -> RUN.
- Any state: clr -> CLEAR. clr has priority over ss when both pulses occur in the same cycle.
- CLEAR: unconditional -> IDLE on the next edge. CLEAR lasts exactly 1 cycle.
  - A clr pulse arriving in that same cycle re-enters CLEAR.
  - ss pulses are ignored while in CLEAR.

Outputs:
- `mode` is the registered state encoding.
- `running` and `paused` are decodes of the state.
- All outputs are registered. No combinational path from any button input to any output.

Prescaler:
- Counter width is clog2(DIV).
- In RUN it increments; at DIV-1 it wraps to 0 and tick=1 for that cycle.
- In PAUSE it holds its value, so a resumed period completes the remainder.
- In IDLE and CLEAR it is held at 0.
- First tick after IDLE->RUN is exactly DIV cycles after the transition edge.

Clear:
- tick=1 during the single CLEAR cycle, so the downstream counter samples mode==2 on an enabled edge and clears.
- tick is never high in IDLE or PAUSE.

Boundary conditions:
- rst mid-debounce: the partial count is discarded.
- rst mid-period: the partial period is discarded; no tick.
- A button held continuously produces one pulse only.
- Bounce shorter than DB_CYCLES produces no pulse.

Decomposition:
- Shared include/package stopwatch_defs holds:
  - mode/state codes MODE_IDLE=0, MODE_RUN=1, MODE_CLEAR=2, MODE_PAUSE=3;
  - the 3-bit mode width.
- These are used by this block and the decade counters.
- One sub-module, btn_debounce (synchronizer + debounce counter + rising-edge pulse, parameter DB_CYCLES), instantiated twice.
- The FSM and the prescaler stay in the top module.

Test Plan (DIV=4, DB_CYCLES=3):
1. Reset and start:
   - Stimulus: rst high for 2 cycles, then low; hold btn_ss high from cycle 10 to 20.
   - Required: mode=0 until the pulse, then mode=1, running=1; tick at +4, +8, +12 cycles after the transition.
   - Only one pulse despite the long hold.
2. Pause/resume:
   - Stimulus: press ss 2 cycles after a tick; after the debounce latency, press ss again.
   - Required: mode 1->3->1; no tick while mode=3.
   - The next tick comes after exactly the remaining period cycles after re-entering RUN (total enabled cycles per period = 4).
3. Clear from RUN:
   - Stimulus: press clr.
   - Required: exactly one cycle with mode=2 and tick=1, then mode=0, tick=0, running=0; prescaler restarts from 0 on the next start.
4. Simultaneous presses:
   - Stimulus: btn_ss and btn_clr rise on the same cycle in PAUSE.
   - Required: mode goes to 2 then 0; never 1.
5. Bounce rejection:
   - Stimulus: btn_ss toggles every 2 cycles for 20 cycles, then returns low.
   - Required: no pulse and mode unchanged; then a clean 5-cycle press yields exactly one transition.
6. Async reset mid-RUN:
   - Stimulus: assert rst between clock edges at prescaler=2.
   - Required: mode=0, tick=0 immediately, without waiting for a clk edge; no tick after release until a new start.
